ram_ahb_dp: RTL and testbench
=============================

Name: ram_ahb_dp

Overview:
- Parametrised AHB-Lite slave RAM built on a simple dual-port byte-enable block RAM (port A write, port B read).
- Generalises the fixed 128KB FPGA RAM with:
  - configurable depth;
  - separate read and write wait states;
  - per-byte write-to-read forwarding;
  - a read-data hold register;
  - an optional ERROR response for illegal transfers.
- Sits on the system AHB matrix as the main data/instruction RAM slave.

Parameters:
ADDR_W, 17, byte address bits decoded; depth = 2^(ADDR_W-2) words (17 -> 128KB)
WAIT_RD, 0, data-phase wait cycles for reads (0..15)
WAIT_WR, 0, data-phase wait cycles for writes (0..15)

Ports:
CLK  input  1  system clock, rising edge
RES  input  1  reset, asynchronous, active-high
S_HSEL  input  1  slave select
S_HTRANS  input  2  transfer type; bit1 = NONSEQ/SEQ
S_HWRITE  input  1  1 = write
S_HMASTLOCK  input  1  ignored
S_HSIZE  input  3  000 byte, 001 half, 010 word
S_HBURST  input  3  ignored
S_HPROT  input  4  ignored
S_HADDR  input  32  byte address; bits [ADDR_W-1:0] used
S_HWDATA  input  32  write data (data phase)
S_HREADY  input  1  bus ready
S_HREADYOUT  output  1  slave ready
S_HRDATA  output  32  read data
S_HRESP  output  1  0 OKAY, 1 ERROR

Behaviour:
- Clock and reset: one clock CLK. Reset RES is asynchronous and active-high. All registers clear on RES.
  - Reset values: S_HREADYOUT=1, S_HRESP=0, S_HRDATA=0.
  - RES mid data phase: the transfer is aborted and no RAM write occurs.
- Accept: addr-phase accept = S_HSEL & S_HREADY & S_HREADYOUT & S_HTRANS[1]. On accept, register addr, write, size and kind into data-phase state.
- IDLE/BUSY or unselected: zero-wait OKAY; no data phase.
- Data-phase FSM states: IDLE, WAIT, LAST, ERR1, ERR2.
  - From IDLE on accept: go to WAIT if the wait count for the kind (WAIT_RD or WAIT_WR) is >0, otherwise to LAST.
  - WAIT: counter increments. When counter==wait-1, go to LAST.
  - LAST: S_HREADYOUT=1. On a new accept, re-enter per the new kind; otherwise go to IDLE.
  - S_HREADYOUT=0 in WAIT and ERR1; 1 in all other states.
- Read:
  - RAM port B read enable = accept & ~S_HWRITE, address S_HADDR[ADDR_W-1:2]. RAM q is valid the following cycle (first data-phase cycle).
  - On the first data-phase cycle, capture merged q into the 32-bit hold register.
  - S_HRDATA = merged q in the first cycle, hold register in later cycles. S_HRDATA is driven only in LAST of a read; otherwise 0.
  - Read latency = 1 + WAIT_RD cycles from the address phase.
- Write:
  - Performed on RAM port A only in LAST of a write data phase, using S_HWDATA and the registered word address.
  - Byte enables: byte -> lane addr[1:0]; half -> lanes {1,0} or {3,2} by addr[1]; word -> all lanes.
- Forwarding:
  - Applies when a read accept coincides with a LAST write to the same word.
  - For each written lane, set a contention flag and store that write byte. The read data for the lane comes from the stored byte, not from q.
  - Unwritten lanes come from q.
  - Flags clear on the next accept.
- Write latency: data is visible to a read issued in the same cycle as the write's LAST (via forwarding) or to any later read.
- S_HRESP=0 in all cases except as defined under Optional Feature.

Optional Feature:
- Macro: RAM_AHB_ERR_EN.
- When defined, an accepted transfer is illegal if any of:
  - S_HSIZE > 010;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - S_HADDR[31:ADDR_W] != 0 (out of range while selected).
- Illegal transfer response: two-cycle ERROR.
  - ERR1: S_HREADYOUT=0, S_HRESP=1.
  - ERR2: S_HREADYOUT=1, S_HRESP=1.
  - No RAM write, no forwarding, S_HRDATA=0.
- When not defined:
  - low address bits are ignored for lane selection beyond the size rules;
  - sizes >010 behave as word;
  - upper address bits alias;
  - S_HRESP is tied to 0.

Decomposition:
- Shared package/include holds: HTRANS/HSIZE encodings, HRESP_OKAY/HRESP_ERROR constants, and the FSM state encodings.
- One sub-module, ram_dp_be: inferred simple dual-port RAM, parameter AW.
  - Port A: wr_en, 4-bit byte enable, addr, wdata.
  - Port B: rd_en, addr, registered q.

Test Plan:
- WAIT_RD=0, WAIT_WR=0: write word 0x12345678 to 0x100, then read 0x100. Required: HRDATA=0x12345678 in the cycle after the read address phase; HREADYOUT stays 1 throughout.
- Back-to-back: write byte 0xAB to 0x203 whose data phase overlaps a read address phase of 0x200, with the word previously 0x11223344. Required: HRDATA=0xAB223344 (lane 3 forwarded).
- WAIT_RD=2, WAIT_WR=1: read 0x40 holding 0xCAFEF00D. Required: HREADYOUT=0 for 2 cycles, then 1 with HRDATA=0xCAFEF00D; a write has exactly 1 low cycle.
- Halfword write 0xBEEF to 0x302 over 0xFFFFFFFF, then read. Required: word reads 0xBEEFFFFF.
- With RAM_AHB_ERR_EN: word write to 0x401 with data 0x0. Required: HREADYOUT 0 then 1 with HRESP=1 in both cycles; a subsequent read of 0x400 returns the old value unchanged.
- Assert RES during the WAIT of a write to 0x500. Required: HREADYOUT=1, HRESP=0, HRDATA=0 immediately; 0x500 is unchanged.

Source files
------------

// File: rtl/ram_ahb_dp_pkg.sv
// ram_ahb_dp_pkg -- shared encodings for the AHB-Lite dual-port RAM slave.
//   HTRANS / HSIZE / HRESP encodings, data-phase FSM states, and the
//   size/lane -> byte-enable helper used by both the write path and forwarding.
package ram_ahb_dp_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_LAST,
    ST_ERR1,
    ST_ERR2
  } dp_state_e;

  // Sizes above word fall through to the all-lanes case.
  function automatic logic [3:0] lane_be(input logic [2:0] size, input logic [1:0] lane);
    case (size)
      HSIZE_BYTE: return 4'b0001 << lane;
      HSIZE_HALF: return lane[1] ? 4'b1100 : 4'b0011;
      default:    return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ram_dp_be.sv
// ram_dp_be -- inferred simple dual-port RAM, 32-bit words, byte enables.
//   Port A: wr_en, be[3:0], wr_addr, wdata (write only)
//   Port B: rd_en, rd_addr, q (registered read, old data on same-address collision)
//   The array and q carry no reset so the tools can map this onto block RAM.
module ram_dp_be #(
  parameter int AW = 15
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [3:0]    be,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wdata,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   q
);

  logic [31:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (wr_en)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[wr_addr][8*i +: 8] <= wdata[8*i +: 8];
    if (rd_en) q <= mem[rd_addr];
  end

endmodule

// File: rtl/ram_ahb_dp.sv
// ram_ahb_dp -- AHB-Lite slave RAM on a simple dual-port byte-enable block RAM.
//   CLK/RES         clock, async active-high reset
//   S_H*            AHB-Lite slave port (HMASTLOCK/HBURST/HPROT ignored)
//   S_HREADYOUT     low during programmed wait cycles and the first ERROR cycle
//   S_HRDATA        valid only in the last data-phase cycle of a read, else 0
//   S_HRESP         OKAY, or two-cycle ERROR when RAM_AHB_ERR_EN is defined
// Optional feature macro: RAM_AHB_ERR_EN (illegal size/alignment/range -> ERROR).
// Writes land in the last data-phase cycle; a read accepted in that same cycle
// gets the written bytes through a per-lane forwarding register.
module ram_ahb_dp
  import ram_ahb_dp_pkg::*;
#(
  parameter int ADDR_W  = 17,
  parameter int WAIT_RD = 0,
  parameter int WAIT_WR = 0
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        S_HSEL,
  input  logic [1:0]  S_HTRANS,
  input  logic        S_HWRITE,
  input  logic        S_HMASTLOCK,
  input  logic [2:0]  S_HSIZE,
  input  logic [2:0]  S_HBURST,
  input  logic [3:0]  S_HPROT,
  input  logic [31:0] S_HADDR,
  input  logic [31:0] S_HWDATA,
  input  logic        S_HREADY,
  output logic        S_HREADYOUT,
  output logic [31:0] S_HRDATA,
  output logic        S_HRESP
);

  localparam int         AW  = ADDR_W - 2;
  localparam logic [3:0] WRD = 4'(WAIT_RD);
  localparam logic [3:0] WWR = 4'(WAIT_WR);

  dp_state_e     state, state_nx;
  logic [AW-1:0] waddr_q;
  logic [1:0]    lane_q;
  logic [2:0]    size_q;
  logic          wr_q, first_q;
  logic [3:0]    cnt;
  logic [3:0]    fwd_be;
  logic [31:0]   fwd_data, hold, merged, q;

  logic acc, illegal, wr_last;
  logic [3:0] wait_new, wait_cur, be_q;

  assign acc      = S_HSEL & S_HREADY & S_HREADYOUT & S_HTRANS[1];
  assign wait_new = S_HWRITE ? WWR : WRD;
  assign wait_cur = wr_q ? WWR : WRD;
  assign wr_last  = (state == ST_LAST) & wr_q;
  assign be_q     = lane_be(size_q, lane_q);

`ifdef RAM_AHB_ERR_EN
  assign illegal = (S_HSIZE > HSIZE_WORD)
                 | ((S_HSIZE == HSIZE_HALF) & S_HADDR[0])
                 | ((S_HSIZE == HSIZE_WORD) & (|S_HADDR[1:0]))
                 | (|S_HADDR[31:ADDR_W]);
  assign S_HRESP = (state == ST_ERR1 || state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
`else
  assign illegal = 1'b0;
  assign S_HRESP = HRESP_OKAY;
`endif

  logic unused_ok;
  assign unused_ok = ^{S_HTRANS[0], S_HMASTLOCK, S_HBURST, S_HPROT, S_HADDR[31:ADDR_W]};

  assign S_HREADYOUT = !(state == ST_WAIT || state == ST_ERR1);

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE, ST_LAST, ST_ERR2: begin
        if (acc) state_nx = illegal ? ST_ERR1 : ((wait_new != 4'd0) ? ST_WAIT : ST_LAST);
        else     state_nx = ST_IDLE;
      end
      ST_WAIT: if (cnt == wait_cur - 4'd1) state_nx = ST_LAST;
      ST_ERR1: state_nx = ST_ERR2;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state    <= ST_IDLE;
      waddr_q  <= '0;
      lane_q   <= '0;
      size_q   <= '0;
      wr_q     <= 1'b0;
      first_q  <= 1'b0;
      cnt      <= '0;
      fwd_be   <= '0;
      fwd_data <= '0;
      hold     <= '0;
    end else begin
      state   <= state_nx;
      first_q <= acc;
      // Only counts while in WAIT, so it is always 0 on entry to WAIT.
      cnt     <= (state == ST_WAIT) ? cnt + 4'd1 : 4'd0;
      if (acc) begin
        waddr_q  <= S_HADDR[ADDR_W-1:2];
        lane_q   <= S_HADDR[1:0];
        size_q   <= S_HSIZE;
        wr_q     <= S_HWRITE;
        // The RAM returns pre-write data for this read, so capture the bytes
        // being written this cycle and substitute them lane by lane.
        fwd_be   <= (wr_last && !S_HWRITE && S_HADDR[ADDR_W-1:2] == waddr_q) ? be_q : 4'd0;
        fwd_data <= S_HWDATA;
      end
      if (first_q) hold <= merged;
    end
  end

  always_comb begin
    merged = q;
    for (int i = 0; i < 4; i++)
      if (fwd_be[i]) merged[8*i +: 8] = fwd_data[8*i +: 8];
  end

  assign S_HRDATA = (state == ST_LAST && !wr_q) ? (first_q ? merged : hold) : 32'd0;

  ram_dp_be #(.AW(AW)) u_ram (
    .clk    (CLK),
    .wr_en  (wr_last),
    .be     (be_q),
    .wr_addr(waddr_q),
    .wdata  (S_HWDATA),
    .rd_en  (acc & ~S_HWRITE),
    .rd_addr(S_HADDR[ADDR_W-1:2]),
    .q      (q)
  );

endmodule

// File: tb/tb_ram_ahb_dp.sv
// tb_ram_ahb_dp -- directed bench: instance 0 has no wait states,
// instance 1 has WAIT_RD=2 / WAIT_WR=1. Both share clock and reset.
module tb_ram_ahb_dp;
  import ram_ahb_dp_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        hsel[2];
  logic [1:0]  htrans[2];
  logic        hwrite[2];
  logic [2:0]  hsize[2];
  logic [31:0] haddr[2];
  logic [31:0] hwdata[2];
  logic        hreadyout[2];
  logic        hresp[2];
  logic [31:0] hrdata[2];

  ram_ahb_dp #(.ADDR_W(17), .WAIT_RD(0), .WAIT_WR(0)) u0 (
    .CLK(clk), .RES(rst), .S_HSEL(hsel[0]), .S_HTRANS(htrans[0]), .S_HWRITE(hwrite[0]),
    .S_HMASTLOCK(1'b0), .S_HSIZE(hsize[0]), .S_HBURST(3'b000), .S_HPROT(4'b0011),
    .S_HADDR(haddr[0]), .S_HWDATA(hwdata[0]), .S_HREADY(hreadyout[0]),
    .S_HREADYOUT(hreadyout[0]), .S_HRDATA(hrdata[0]), .S_HRESP(hresp[0]));

  ram_ahb_dp #(.ADDR_W(17), .WAIT_RD(2), .WAIT_WR(1)) u1 (
    .CLK(clk), .RES(rst), .S_HSEL(hsel[1]), .S_HTRANS(htrans[1]), .S_HWRITE(hwrite[1]),
    .S_HMASTLOCK(1'b0), .S_HSIZE(hsize[1]), .S_HBURST(3'b000), .S_HPROT(4'b0011),
    .S_HADDR(haddr[1]), .S_HWDATA(hwdata[1]), .S_HREADY(hreadyout[1]),
    .S_HREADYOUT(hreadyout[1]), .S_HRDATA(hrdata[1]), .S_HRESP(hresp[1]));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Single transfer from an idle bus; returns data/response of the final
  // data-phase cycle, the response of the first data cycle, and the
  // number of HREADYOUT-low cycles.
  task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, output logic [31:0] rd, output int low,
                      output logic resp0, output logic resp1);
    @(negedge clk);
    hsel[d] = 1'b1; htrans[d] = HTRANS_NONSEQ; hwrite[d] = w; haddr[d] = a; hsize[d] = sz;
    @(posedge clk);
    @(negedge clk);
    hsel[d] = 1'b0; htrans[d] = HTRANS_IDLE; hwdata[d] = wd;
    low = 0;
    resp0 = hresp[d];
    while (!hreadyout[d] && low < 40) begin low++; @(negedge clk); end
    rd = hrdata[d];
    resp1 = hresp[d];
  endtask

  // Write whose data phase overlaps a word-read address phase.
  task automatic pipe(input int d, input logic [31:0] wa, input logic [2:0] wsz,
                      input logic [31:0] wd, input logic [31:0] ra, output logic [31:0] rd);
    int n;
    @(negedge clk);
    hsel[d] = 1'b1; htrans[d] = HTRANS_NONSEQ; hwrite[d] = 1'b1; haddr[d] = wa; hsize[d] = wsz;
    @(posedge clk);
    @(negedge clk);
    hwrite[d] = 1'b0; haddr[d] = ra; hsize[d] = HSIZE_WORD; hwdata[d] = wd;
    n = 0;
    while (!hreadyout[d] && n < 40) begin n++; @(negedge clk); end
    @(posedge clk);
    @(negedge clk);
    hsel[d] = 1'b0; htrans[d] = HTRANS_IDLE;
    n = 0;
    while (!hreadyout[d] && n < 40) begin n++; @(negedge clk); end
    rd = hrdata[d];
  endtask

  initial begin
    logic [31:0] rd;
    int low;
    logic r0, r1;

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      hsel[i] = 1'b0; htrans[i] = HTRANS_IDLE; hwrite[i] = 1'b0; hsize[i] = HSIZE_WORD;
      haddr[i] = '0; hwdata[i] = '0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_hreadyout", 32'(hreadyout[i]), 32'd1);
      chk("rst_hresp",     32'(hresp[i]),     32'd0);
      chk("rst_hrdata",    hrdata[i],         32'd0);
    end
    rst = 1'b0;

    // zero-wait word write then read
    xfer(0, 1'b1, 32'h100, HSIZE_WORD, 32'h12345678, rd, low, r0, r1);
    chk("w0_low", 32'(low), 32'd0);
    chk("w0_rdata_zero", rd, 32'd0);
    xfer(0, 1'b0, 32'h100, HSIZE_WORD, 32'h0, rd, low, r0, r1);
    chk("r0_low", 32'(low), 32'd0);
    chk("r0_data", rd, 32'h12345678);
    chk("r0_resp", 32'(r1), 32'd0);

    // byte write forwarded into an overlapping read
    xfer(0, 1'b1, 32'h200, HSIZE_WORD, 32'h11223344, rd, low, r0, r1);
    pipe(0, 32'h203, HSIZE_BYTE, 32'hAB5A5A5A, 32'h200, rd);
    chk("fwd0_data", rd, 32'hAB223344);
    xfer(0, 1'b0, 32'h200, HSIZE_WORD, 32'h0, rd, low, r0, r1);
    chk("fwd0_ram", rd, 32'hAB223344);

    // halfword and byte lane writes
    xfer(0, 1'b1, 32'h300, HSIZE_WORD, 32'hFFFFFFFF, rd, low, r0, r1);
    xfer(0, 1'b1, 32'h302, HSIZE_HALF, 32'hBEEF1234, rd, low, r0, r1);
    xfer(0, 1'b0, 32'h300, HSIZE_WORD, 32'h0, rd, low, r0, r1);
    chk("half_data", rd, 32'hBEEFFFFF);
    xfer(0, 1'b1, 32'h301, HSIZE_BYTE, 32'h7777C377, rd, low, r0, r1);
    xfer(0, 1'b0, 32'h300, HSIZE_WORD, 32'h0, rd, low, r0, r1);
    chk("byte1_data", rd, 32'hBEEFC3FF);

    // wait states
    xfer(1, 1'b1, 32'h40, HSIZE_WORD, 32'hCAFEF00D, rd, low, r0, r1);
    chk("w1_low", 32'(low), 32'd1);
    xfer(1, 1'b0, 32'h40, HSIZE_WORD, 32'h0, rd, low, r0, r1);
    chk("r1_low", 32'(low), 32'd2);
    chk("r1_data", rd, 32'hCAFEF00D);
    pipe(1, 32'h42, HSIZE_HALF, 32'h12349999, 32'h40, rd);
    chk("fwd1_data", rd, 32'h1234F00D);
    xfer(1, 1'b0, 32'h40, HSIZE_WORD, 32'h0, rd, low, r0, r1);
    chk("fwd1_ram", rd, 32'h1234F00D);

`ifdef RAM_AHB_ERR_EN
    xfer(0, 1'b1, 32'h400, HSIZE_WORD, 32'h0BADF00D, rd, low, r0, r1);
    xfer(0, 1'b1, 32'h401, HSIZE_WORD, 32'h0, rd, low, r0, r1);
    chk("err_low", 32'(low), 32'd1);
    chk("err_resp1", 32'(r0), 32'd1);
    chk("err_resp2", 32'(r1), 32'd1);
    xfer(0, 1'b0, 32'h400, HSIZE_WORD, 32'h0, rd, low, r0, r1);
    chk("err_nowrite", rd, 32'h0BADF00D);
    chk("err_after_resp", 32'(r1), 32'd0);
    xfer(0, 1'b0, 32'h40400, HSIZE_WORD, 32'h0, rd, low, r0, r1);
    chk("oor_resp", 32'(r1), 32'd1);
    chk("oor_rdata", rd, 32'd0);
`else
    xfer(0, 1'b1, 32'h400, HSIZE_WORD, 32'h0BADF00D, rd, low, r0, r1);
    xfer(0, 1'b1, 32'h401, HSIZE_WORD, 32'h0, rd, low, r0, r1);
    chk("mis_low", 32'(low), 32'd0);
    chk("mis_resp", 32'(r1), 32'd0);
    xfer(0, 1'b0, 32'h400, HSIZE_WORD, 32'h0, rd, low, r0, r1);
    chk("mis_word", rd, 32'd0);
    xfer(0, 1'b1, 32'h20400, HSIZE_WORD, 32'h600DCAFE, rd, low, r0, r1);
    xfer(0, 1'b0, 32'h400, HSIZE_WORD, 32'h0, rd, low, r0, r1);
    chk("alias_data", rd, 32'h600DCAFE);
`endif

    // reset during a write wait cycle aborts the write
    xfer(1, 1'b1, 32'h500, HSIZE_WORD, 32'h55AA55AA, rd, low, r0, r1);
    @(negedge clk);
    hsel[1] = 1'b1; htrans[1] = HTRANS_NONSEQ; hwrite[1] = 1'b1; haddr[1] = 32'h500;
    hsize[1] = HSIZE_WORD;
    @(posedge clk);
    @(negedge clk);
    hsel[1] = 1'b0; htrans[1] = HTRANS_IDLE; hwdata[1] = 32'hDEADBEEF;
    chk("rstw_wait", 32'(hreadyout[1]), 32'd0);
    rst = 1'b1;
    #1;
    chk("rstw_hreadyout", 32'(hreadyout[1]), 32'd1);
    chk("rstw_hresp", 32'(hresp[1]), 32'd0);
    chk("rstw_hrdata", hrdata[1], 32'd0);
    @(negedge clk);
    rst = 1'b0;
    xfer(1, 1'b0, 32'h500, HSIZE_WORD, 32'h0, rd, low, r0, r1);
    chk("rstw_unchanged", rd, 32'h55AA55AA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
